tick_gen: RTL

TICK_GEN -- requirements
Module: tick_gen

---
 rtl/tick_gen.sv | 103 ++++++++++
 1 files changed

// File: rtl/tick_gen.sv
// tick_gen: NUM_CH independent programmable dividers, each producing a one-cycle tick and a square wave.
// Define TICK_GEN_STEP_EN to add pause/single-step control of channel 0.
module tick_gen #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 24,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_DIVS = {24'd1666667, 24'd5000}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    wr_en,
  input  logic [2:0]              wr_ch,
  input  logic [CNT_W-1:0]        wr_div,
  input  logic                    pause,
  input  logic                    step,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       sq,
  output logic [NUM_CH*CNT_W-1:0] div_q
);

  logic step_rise;

`ifdef TICK_GEN_STEP_EN
  logic step_q, step_d;

  always_comb step_d = step;

  always_ff @(posedge clk) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step_d;
  end

  assign step_rise = step & ~step_q;
`else
  logic unused_ok;
  assign unused_ok = ^{pause, step};
  assign step_rise = 1'b0;
`endif

  // A divisor of 0 or 1 both mean "tick on every enabled cycle".
  function automatic logic at_wrap(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] dv);
    return (dv <= CNT_W'(1)) || (cnt >= dv - CNT_W'(1));
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             sel, hold;

    assign sel = wr_en && (wr_ch == 3'(c));

`ifdef TICK_GEN_STEP_EN
    assign hold = (c == 0) && pause;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
      cnt_d  = cnt_q;
      per_d  = per_q;
      tick_d = 1'b0;
      sq_d   = sq_q;
      if (sel) begin
        per_d = wr_div;
        cnt_d = '0;
      end else if (hold) begin
        if (step_rise) begin
          tick_d = 1'b1;
          sq_d   = ~sq_q;
        end
      end else if (en[c]) begin
        if (at_wrap(cnt_q, per_q)) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          sq_d   = ~sq_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q  <= '0;
        per_q  <= DEF_DIVS[c*CNT_W +: CNT_W];
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        per_q  <= per_d;
        tick_q <= tick_d;
        sq_q   <= sq_d;
      end
    end

    assign tick[c]                  = tick_q;
    assign sq[c]                    = sq_q;
    assign div_q[c*CNT_W +: CNT_W]  = per_q;
  end

endmodule
